// File: rtl/dec2ascii_fmt_pkg.sv
// Shared types, ASCII constants and BCD helpers for the decimal-to-ASCII formatter.
package dec_fmt_pkg;

    localparam int BIN_W      = 25;
    localparam int BCD_DIGITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV_INT,
        ST_CONV_FRAC,
        ST_EMIT
    } fmt_state_e;

    typedef enum logic [2:0] {
        PH_SIGN,
        PH_INT,
        PH_DOT,
        PH_FRAC,
        PH_E,
        PH_ESIGN,
        PH_ETENS,
        PH_EUNITS
    } fmt_phase_e;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_E     = 8'h45;

    // True when any BCD digit at position k or above is nonzero.
    function automatic logic bcd_nonzero_above(input logic [4*BCD_DIGITS-1:0] digits, input int k);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (i >= k) begin
                hit = hit | (digits[4*i +: 4] != 4'd0);
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/dec2ascii_fmt_bin2bcd_seq.sv
// Iterative double-dabble: 25-bit binary to 8 BCD digits, one bit per cycle.
// The first shift happens on the start edge so done lands 25 cycles after start.
module bin2bcd_seq
    import dec_fmt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [24:0] bin,
    output logic        busy,
    output logic        done,
    output logic [31:0] bcd
);

    logic [24:0] sh_r;
    logic [31:0] bcd_r;
    logic [4:0]  cnt_r;
    logic        busy_r;
    logic        done_r;
    logic [27:0] adj_s;

    // Add-3 correction on the seven low digits; the top digit never reaches 5 for 25-bit input.
    always_comb begin
        adj_s = 28'd0;
        for (int i = 0; i < 7; i++) begin
            adj_s[4*i +: 4] = (bcd_r[4*i +: 4] >= 4'd5) ? (bcd_r[4*i +: 4] + 4'd3) : bcd_r[4*i +: 4];
        end
    end

    // Load/shift sequencer with a one-cycle done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_r   <= 25'd0;
            bcd_r  <= 32'd0;
            cnt_r  <= 5'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            bcd_r  <= {31'd0, bin[24]};
            sh_r   <= {bin[23:0], 1'b0};
            cnt_r  <= 5'd24;
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            bcd_r  <= {bcd_r[30:28], adj_s, sh_r[24]};
            sh_r   <= {sh_r[23:0], 1'b0};
            cnt_r  <= cnt_r - 5'd1;
            done_r <= (cnt_r == 5'd1);
            busy_r <= (cnt_r != 5'd1);
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign bcd  = bcd_r;

endmodule

// File: rtl/dec2ascii_fmt.sv
// Streams a sign/integer/fraction/exponent triple as ASCII scientific notation,
// sharing one sequential binary-to-BCD converter for both numeric fields.
module dec2ascii_fmt #(
    parameter int FRAC_DIGITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [24:0] nguyen,
    input  logic [24:0] le,
    input  logic [5:0]  luythua,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_char,
    output logic        out_last,
    output logic        frac_ovf
);
    import dec_fmt_pkg::*;

    fmt_state_e  state_r;
    fmt_phase_e  phase_r, first_phase_s, next_phase_s, sel_phase_s;
    logic [2:0]  ptr_r, first_ptr_s, next_ptr_s, sel_ptr_s, lead_idx_s;
    logic        sign_r, ovf_flag_r;
    logic [24:0] le_r;
    logic [5:0]  exp_r;
    logic [31:0] int_bcd_r;
    logic        in_ready_r, out_valid_r, out_last_r, frac_ovf_r;
    logic [7:0]  out_char_r, char_s;
    logic [6:0]  exp_mag_s;
    logic [3:0]  exp_tens_s, exp_units_s;
    logic        accept_s, conv_start_s, conv_busy_s, conv_done_s;
    logic [24:0] conv_bin_s;
    logic [31:0] conv_bcd_s;

    assign accept_s     = in_valid & in_ready_r & (state_r == ST_IDLE);
    assign conv_start_s = (accept_s | ((state_r == ST_CONV_INT) & conv_done_s)) & ~conv_busy_s;
    assign conv_bin_s   = (state_r == ST_IDLE) ? nguyen : le_r;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start_s),
        .bin   (conv_bin_s),
        .busy  (conv_busy_s),
        .done  (conv_done_s),
        .bcd   (conv_bcd_s)
    );

    // Highest nonzero integer digit; zero value maps to digit 0 so a single '0' prints.
    always_comb begin
        lead_idx_s = 3'd0;
        for (int i = 0; i < 8; i++) begin
            lead_idx_s = (int_bcd_r[4*i +: 4] != 4'd0) ? 3'(i) : lead_idx_s;
        end
    end

    // Exponent magnitude and tens/units split by compare-subtract.
    always_comb begin
        exp_mag_s = exp_r[5] ? (7'd0 - {exp_r[5], exp_r}) : {1'b0, exp_r};
        if (exp_mag_s >= 7'd30) begin
            exp_tens_s  = 4'd3;
            exp_units_s = 4'(exp_mag_s - 7'd30);
        end else if (exp_mag_s >= 7'd20) begin
            exp_tens_s  = 4'd2;
            exp_units_s = 4'(exp_mag_s - 7'd20);
        end else if (exp_mag_s >= 7'd10) begin
            exp_tens_s  = 4'd1;
            exp_units_s = 4'(exp_mag_s - 7'd10);
        end else begin
            exp_tens_s  = 4'd0;
            exp_units_s = 4'(exp_mag_s);
        end
    end

    // Character position sequencing: first position on EMIT entry, successor afterwards.
    always_comb begin
        first_phase_s = sign_r ? PH_SIGN : PH_INT;
        first_ptr_s   = sign_r ? 3'd0 : lead_idx_s;
        next_phase_s  = phase_r;
        next_ptr_s    = ptr_r;
        case (phase_r)
            PH_SIGN: begin
                next_phase_s = PH_INT;
                next_ptr_s   = lead_idx_s;
            end
            PH_INT: begin
                next_phase_s = (ptr_r == 3'd0) ? PH_DOT : PH_INT;
                next_ptr_s   = (ptr_r == 3'd0) ? 3'd0 : (ptr_r - 3'd1);
            end
            PH_DOT: begin
                next_phase_s = PH_FRAC;
                next_ptr_s   = 3'(FRAC_DIGITS - 1);
            end
            PH_FRAC: begin
                next_phase_s = (ptr_r == 3'd0) ? PH_E : PH_FRAC;
                next_ptr_s   = (ptr_r == 3'd0) ? 3'd0 : (ptr_r - 3'd1);
            end
            PH_E:      next_phase_s = PH_ESIGN;
            PH_ESIGN:  next_phase_s = PH_ETENS;
            PH_ETENS:  next_phase_s = PH_EUNITS;
            PH_EUNITS: next_phase_s = PH_EUNITS;
            default:   next_phase_s = PH_SIGN;
        endcase
        sel_phase_s = (state_r == ST_EMIT) ? next_phase_s : first_phase_s;
        sel_ptr_s   = (state_r == ST_EMIT) ? next_ptr_s : first_ptr_s;
    end

    // ASCII for the selected position; fraction digits are read from the idle converter.
    always_comb begin
        char_s = ASCII_ZERO;
        case (sel_phase_s)
            PH_SIGN:   char_s = ASCII_MINUS;
            PH_INT:    char_s = ASCII_ZERO + {4'd0, int_bcd_r[{sel_ptr_s, 2'b00} +: 4]};
            PH_DOT:    char_s = ASCII_DOT;
            PH_FRAC:   char_s = ASCII_ZERO + {4'd0, conv_bcd_s[{sel_ptr_s, 2'b00} +: 4]};
            PH_E:      char_s = ASCII_E;
            PH_ESIGN:  char_s = exp_r[5] ? ASCII_MINUS : ASCII_PLUS;
            PH_ETENS:  char_s = ASCII_ZERO + {4'd0, exp_tens_s};
            PH_EUNITS: char_s = ASCII_ZERO + {4'd0, exp_units_s};
            default:   char_s = ASCII_ZERO;
        endcase
    end

    // Control FSM with registered handshake and character outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_char_r  <= 8'h00;
            out_last_r  <= 1'b0;
            frac_ovf_r  <= 1'b0;
            sign_r      <= 1'b0;
            le_r        <= 25'd0;
            exp_r       <= 6'd0;
            int_bcd_r   <= 32'd0;
            ovf_flag_r  <= 1'b0;
            phase_r     <= PH_SIGN;
            ptr_r       <= 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        sign_r     <= in_sign;
                        le_r       <= le;
                        exp_r      <= luythua;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_CONV_INT;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_CONV_INT: begin
                    if (conv_done_s) begin
                        int_bcd_r <= conv_bcd_s;
                        state_r   <= ST_CONV_FRAC;
                    end
                end
                ST_CONV_FRAC: begin
                    if (conv_done_s) begin
                        ovf_flag_r  <= bcd_nonzero_above(conv_bcd_s, FRAC_DIGITS);
                        phase_r     <= first_phase_s;
                        ptr_r       <= first_ptr_s;
                        out_char_r  <= char_s;
                        out_valid_r <= 1'b1;
                        out_last_r  <= 1'b0;
                        frac_ovf_r  <= 1'b0;
                        state_r     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_valid_r & out_ready) begin
                        if (out_last_r) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            frac_ovf_r  <= 1'b0;
                            in_ready_r  <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else begin
                            phase_r    <= next_phase_s;
                            ptr_r      <= next_ptr_s;
                            out_char_r <= char_s;
                            out_last_r <= (next_phase_s == PH_EUNITS);
                            frac_ovf_r <= (next_phase_s == PH_EUNITS) & ovf_flag_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_char  = out_char_r;
    assign out_last  = out_last_r;
    assign frac_ovf  = frac_ovf_r;

endmodule

// File: tb/tb_dec2ascii_fmt.sv
// Directed bench for dec2ascii_fmt: strings, latency, backpressure, busy-ignore and reset abort.
module tb_dec2ascii_fmt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [24:0] nguyen = 25'd0;
    logic [24:0] le = 25'd0;
    logic [5:0]  luythua = 6'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_char;
    logic        out_last;
    logic        frac_ovf;

    int checks = 0;
    int failures = 0;

    string got;
    int    first_k, last_k;
    logic  ovf_last, ovf_elsewhere, unstable, ready_early, timed_out;

    always #5 clk = ~clk;

    dec2ascii_fmt #(.FRAC_DIGITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .nguyen    (nguyen),
        .le        (le),
        .luythua   (luythua),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_last  (out_last),
        .frac_ovf  (frac_ovf)
    );

    task automatic send(input logic s, input logic [24:0] n, input logic [24:0] l, input logic [5:0] e);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        in_sign = s; nguyen = n; le = l; luythua = e; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Observes one output string; k counts cycles after the accept edge (k=1 is T+1).
    task automatic collect(input int mode, input int pulse_k);
        int e;
        logic prev_stall, prev_last, prev_ovf, rdy;
        logic [7:0] prev_char;
        got = ""; first_k = 0; last_k = 0; ovf_last = 1'b0; ovf_elsewhere = 1'b0;
        unstable = 1'b0; ready_early = 1'b0; timed_out = 1'b1;
        e = 0; prev_stall = 1'b0; prev_last = 1'b0; prev_ovf = 1'b0; prev_char = 8'h00;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == pulse_k) begin
                in_valid = 1'b1; in_sign = 1'b0; nguyen = 25'd5; le = 25'd0; luythua = 6'd1;
            end else begin
                in_valid = 1'b0;
            end
            rdy = 1'b1;
            if (out_valid) begin
                if (first_k == 0) first_k = k;
                rdy = (mode == 0) ? 1'b1 : ((e % 4 == 0) || (e % 4 == 3));
                e++;
            end
            out_ready = rdy;
            if (prev_stall && (out_char !== prev_char || out_last !== prev_last || frac_ovf !== prev_ovf)) unstable = 1'b1;
            if (in_ready) ready_early = 1'b1;
            if (frac_ovf && !out_last) ovf_elsewhere = 1'b1;
            prev_stall = out_valid && !rdy;
            prev_char = out_char; prev_last = out_last; prev_ovf = frac_ovf;
            if (out_valid && rdy) begin
                got = $sformatf("%s%c", got, out_char);
                if (out_last) begin
                    ovf_last = frac_ovf;
                    last_k = k;
                    timed_out = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_char, out_last, frac_ovf} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b vld=%b chr=%h last=%b ovf=%b exp all zero", in_ready, out_valid, out_char, out_last, frac_ovf);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_basic();
        send(1'b1, 25'd1, 25'd23, 6'b111011);
        collect(0, 0);
        checks++;
        if (got != "-1.23E-05" || timed_out) begin
            failures++;
            $display("FAIL basic_string got=%s exp=-1.23E-05", got);
        end
        checks++;
        if (first_k != 51 || last_k != 59) begin
            failures++;
            $display("FAIL basic_timing got first=%0d last=%0d exp first=51 last=59", first_k, last_k);
        end
        checks++;
        if (ovf_last !== 1'b0 || ovf_elsewhere !== 1'b0) begin
            failures++;
            $display("FAIL basic_ovf got last=%b else=%b exp 0 0", ovf_last, ovf_elsewhere);
        end
        checks++;
        if (ready_early !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_ready got=%b exp=0", ready_early);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_done got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_zero_int();
        send(1'b0, 25'd0, 25'd7, 6'd0);
        collect(0, 0);
        checks++;
        if (got != "0.07E+00" || ovf_last !== 1'b0) begin
            failures++;
            $display("FAIL zero_int got=%s ovf=%b exp=0.07E+00 ovf=0", got, ovf_last);
        end
    endtask

    task automatic test_max_ovf();
        send(1'b0, 25'd16777215, 25'd123, 6'b100000);
        collect(0, 0);
        checks++;
        if (got != "16777215.23E-32") begin
            failures++;
            $display("FAIL max_string got=%s exp=16777215.23E-32", got);
        end
        checks++;
        if (ovf_last !== 1'b1 || ovf_elsewhere !== 1'b0) begin
            failures++;
            $display("FAIL max_ovf got last=%b else=%b exp 1 0", ovf_last, ovf_elsewhere);
        end
        checks++;
        if (last_k != 65) begin
            failures++;
            $display("FAIL max_last_cycle got=%0d exp=65", last_k);
        end
    endtask

    task automatic test_patterns();
        send(1'b0, 25'd100, 25'd5, 6'd31);
        collect(0, 0);
        checks++;
        if (got != "100.05E+31") begin
            failures++;
            $display("FAIL pat_inner_zero got=%s exp=100.05E+31", got);
        end
        send(1'b1, 25'd9, 25'd99, 6'b110110);
        collect(0, 0);
        checks++;
        if (got != "-9.99E-10" || ovf_last !== 1'b0) begin
            failures++;
            $display("FAIL pat_neg10 got=%s ovf=%b exp=-9.99E-10 ovf=0", got, ovf_last);
        end
    endtask

    task automatic test_backpressure();
        send(1'b1, 25'd1, 25'd23, 6'b111011);
        collect(1, 0);
        checks++;
        if (got != "-1.23E-05") begin
            failures++;
            $display("FAIL bp_string got=%s exp=-1.23E-05", got);
        end
        checks++;
        if (unstable !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold got unstable=%b exp=0", unstable);
        end
        checks++;
        if (ready_early !== 1'b0) begin
            failures++;
            $display("FAIL bp_busy_ready got=%b exp=0", ready_early);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_done_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_ignore_busy();
        send(1'b1, 25'd1, 25'd23, 6'b111011);
        collect(0, 30);
        checks++;
        if (got != "-1.23E-05" || first_k != 51) begin
            failures++;
            $display("FAIL ignore_busy got=%s first=%0d exp=-1.23E-05 first=51", got, first_k);
        end
    endtask

    task automatic test_reset_abort();
        send(1'b1, 25'd1, 25'd23, 6'b111011);
        for (int k = 1; k <= 30; k++) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_char, out_last, frac_ovf} !== 12'h000) begin
            failures++;
            $display("FAIL abort_conv got rdy=%b vld=%b chr=%h last=%b ovf=%b exp all zero", in_ready, out_valid, out_char, out_last, frac_ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_release_ready got=%b exp=1", in_ready);
        end
        send(1'b1, 25'd1, 25'd23, 6'b111011);
        collect(0, 0);
        checks++;
        if (got != "-1.23E-05" || first_k != 51) begin
            failures++;
            $display("FAIL abort_retry got=%s first=%0d exp=-1.23E-05 first=51", got, first_k);
        end
        send(1'b1, 25'd1, 25'd23, 6'b111011);
        for (int k = 1; k <= 52; k++) begin
            @(negedge clk);
            out_ready = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b1 || out_char !== 8'h2D) begin
            failures++;
            $display("FAIL abort_emit_pre got vld=%b chr=%h exp vld=1 chr=2d", out_valid, out_char);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_char, out_last, frac_ovf} !== 12'h000) begin
            failures++;
            $display("FAIL abort_emit got rdy=%b vld=%b chr=%h last=%b ovf=%b exp all zero", in_ready, out_valid, out_char, out_last, frac_ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_emit_release got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_int();
        test_max_ovf();
        test_patterns();
        test_backpressure();
        test_ignore_busy();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
